ghost_swarm: RTL

Parametrised successor to the single-ghost mover: owns N_GHOST ghosts, advancing each one pixel per game tick. Movement alternates between chasing Pac-Man and LFSR-driven wandering, and collisions against the Pac-Man position are detected in hardware. Sits between the game-logic/keyboard controller (supplies `pac_x`/`pac_y`, `tick`) and the Display block (consumes packed ghost coordinates). A single time-shared update datapath is used, one ghost per clock.

---
 rtl/ghost_swarm_pkg.sv | 24 ++
 rtl/ghost_swarm_step.sv | 86 ++++++++
 rtl/ghost_swarm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ghost_swarm_pkg.sv
// Shared encodings for the ghost swarm: movement directions, mode values, FSM state codes
// and the 16-bit wander LFSR.
package ghost_swarm_pkg;

   typedef enum logic [1:0] {
      DIR_U = 2'd0,
      DIR_D = 2'd1,
      DIR_L = 2'd2,
      DIR_R = 2'd3
   } dir_t;

   localparam logic MODE_CHASE  = 1'b0;
   localparam logic MODE_WANDER = 1'b1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_CAUGHT = 2'd2;

   // Fibonacci LFSR, taps for x^16 + x^14 + x^13 + x^11.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/ghost_swarm_step.sv
// Combinational next position / next direction for one ghost; time-shared by ghost_swarm.
// Screen coordinates: UP decreases y, RIGHT increases x.
module ghost_swarm_step
   import ghost_swarm_pkg::*;
#(
   parameter int X_W   = 10,
   parameter int Y_W   = 9,
   parameter int X_MIN = 8,
   parameter int X_MAX = 631,
   parameter int Y_MIN = 8,
   parameter int Y_MAX = 471
) (
   input  logic [X_W-1:0] gx,
   input  logic [Y_W-1:0] gy,
   input  dir_t           dir,
   input  logic [X_W-1:0] pac_x,
   input  logic [Y_W-1:0] pac_y,
   input  logic           mode,
   input  logic [3:0]     rnd,
   output logic [X_W-1:0] nx,
   output logic [Y_W-1:0] ny,
   output dir_t           ndir
);

   localparam int D_W = (X_W > Y_W) ? X_W + 1 : Y_W + 1;

   logic signed [X_W:0] dx;
   logic signed [Y_W:0] dy;
   logic [X_W:0]        adx, tx;
   logic [Y_W:0]        ady, ty;
   logic                inc_x, dec_x, inc_y, dec_y, at_edge;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      inc_x   = 1'b0;
      dec_x   = 1'b0;
      inc_y   = 1'b0;
      dec_y   = 1'b0;
      at_edge = 1'b0;
      ndir    = dir;
      dx      = $signed({1'b0, pac_x}) - $signed({1'b0, gx});
      dy      = $signed({1'b0, pac_y}) - $signed({1'b0, gy});
      adx     = dx[X_W] ? (X_W+1)'(-dx) : (X_W+1)'(dx);
      ady     = dy[Y_W] ? (Y_W+1)'(-dy) : (Y_W+1)'(dy);

      if (mode == MODE_CHASE) begin
         if (adx == '0 && ady == '0) begin
            inc_x = 1'b0;
         end else if (D_W'(adx) >= D_W'(ady)) begin
            inc_x = ~dx[X_W];
            dec_x =  dx[X_W];
         end else begin
            inc_y = ~dy[Y_W];
            dec_y =  dy[Y_W];
         end
      end else begin
         case (dir)
            DIR_U:   at_edge = (gy <= Y_W'(Y_MIN));
            DIR_D:   at_edge = (gy >= Y_W'(Y_MAX));
            DIR_L:   at_edge = (gx <= X_W'(X_MIN));
            default: at_edge = (gx >= X_W'(X_MAX));
         endcase
         // A blocked or randomly re-rolled ghost turns in place this tick.
         if (at_edge || rnd[1:0] == 2'b00) begin
            ndir = dir_t'(rnd[3:2]);
         end else begin
            case (dir)
               DIR_U:   dec_y = 1'b1;
               DIR_D:   inc_y = 1'b1;
               DIR_L:   dec_x = 1'b1;
               default: inc_x = 1'b1;
            endcase
         end
      end

      tx = {1'b0, gx} + (X_W+1)'(inc_x) - (X_W+1)'(dec_x);
      ty = {1'b0, gy} + (Y_W+1)'(inc_y) - (Y_W+1)'(dec_y);
      if (tx > (X_W+1)'(X_MAX))      nx = X_W'(X_MAX);
      else if (tx < (X_W+1)'(X_MIN)) nx = X_W'(X_MIN);
      else                           nx = tx[X_W-1:0];
      if (ty > (Y_W+1)'(Y_MAX))      ny = Y_W'(Y_MAX);
      else if (ty < (Y_W+1)'(Y_MIN)) ny = Y_W'(Y_MIN);
      else                           ny = ty[Y_W-1:0];
   end

endmodule

// File: rtl/ghost_swarm.sv
// N_GHOST ghosts advanced one pixel per accepted tick through one shared step datapath
// (one ghost per clock), alternating chase/wander phases, with Pac-Man collision detection.
module ghost_swarm
   import ghost_swarm_pkg::*;
#(
   parameter int                     N_GHOST      = 4,
   parameter int                     X_W          = 10,
   parameter int                     Y_W          = 9,
   parameter logic [N_GHOST*X_W-1:0] INIT_X       = {10'd260, 10'd240, 10'd220, 10'd200},
   parameter logic [N_GHOST*Y_W-1:0] INIT_Y       = {4{9'd146}},
   parameter int                     X_MIN        = 8,
   parameter int                     X_MAX        = 631,
   parameter int                     Y_MIN        = 8,
   parameter int                     Y_MAX        = 471,
   parameter int                     HIT_R        = 8,
   parameter int                     CHASE_TICKS  = 240,
   parameter int                     WANDER_TICKS = 120,
   parameter logic [15:0]            LFSR_SEED    = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     enable,
   input  logic                     restart,
   input  logic [X_W-1:0]           pac_x,
   input  logic [Y_W-1:0]           pac_y,
   output logic [N_GHOST*X_W-1:0]   ghost_x,
   output logic [N_GHOST*Y_W-1:0]   ghost_y,
   output logic                     mode,
   output logic                     busy,
   output logic                     hit,
   output logic [2:0]               hit_id,
   output logic                     caught,
   output logic                     overrun
);

   localparam int IDX_W  = (N_GHOST > 1) ? $clog2(N_GHOST) : 1;
   localparam int PH_MAX = (CHASE_TICKS > WANDER_TICKS) ? CHASE_TICKS : WANDER_TICKS;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   logic [X_W-1:0]   gx_q [N_GHOST];
   logic [Y_W-1:0]   gy_q [N_GHOST];
   dir_t             dir_q [N_GHOST];
   logic [1:0]       state;
   logic [IDX_W-1:0] idx, chk_idx;
   logic             chk_vld, coll, accept;
   logic [PH_W-1:0]  phase, phase_inc, phase_lim;
   logic [15:0]      lfsr;
   logic [X_W-1:0]   nx, cx, adx;
   logic [Y_W-1:0]   ny, cy, ady;
   dir_t             ndir;

   ghost_swarm_step #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .X_MIN (X_MIN),
      .X_MAX (X_MAX),
      .Y_MIN (Y_MIN),
      .Y_MAX (Y_MAX)
   ) u_step (
      .gx    (gx_q[idx]),
      .gy    (gy_q[idx]),
      .dir   (dir_q[idx]),
      .pac_x (pac_x),
      .pac_y (pac_y),
      .mode  (mode),
      .rnd   (lfsr[3:0]),
      .nx    (nx),
      .ny    (ny),
      .ndir  (ndir)
   );

   // Collision is judged one cycle after a write, on the registered position of that ghost.
   assign cx        = gx_q[chk_idx];
   assign cy        = gy_q[chk_idx];
   assign adx       = (cx > pac_x) ? cx - pac_x : pac_x - cx;
   assign ady       = (cy > pac_y) ? cy - pac_y : pac_y - cy;
   assign coll      = chk_vld && (adx < X_W'(HIT_R)) && (ady < Y_W'(HIT_R));
   assign accept    = tick && enable && !caught && !coll && (state == ST_IDLE);
   assign phase_inc = phase + 1'b1;
   assign phase_lim = (mode == MODE_WANDER) ? PH_W'(WANDER_TICKS) : PH_W'(CHASE_TICKS);
   assign busy      = (state == ST_SCAN);

   always_comb begin
      for (int k = 0; k < N_GHOST; k++) begin
         ghost_x[k*X_W +: X_W] = gx_q[k];
         ghost_y[k*Y_W +: Y_W] = gy_q[k];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the position array is game state with defined home values, so it is reset like any register.
         for (int k = 0; k < N_GHOST; k++) begin
            gx_q[k]  <= INIT_X[k*X_W +: X_W];
            gy_q[k]  <= INIT_Y[k*Y_W +: Y_W];
            dir_q[k] <= DIR_R;
         end
         state   <= ST_IDLE;
         idx     <= '0;
         chk_idx <= '0;
         chk_vld <= 1'b0;
         mode    <= MODE_CHASE;
         phase   <= '0;
         lfsr    <= LFSR_SEED;
         hit     <= 1'b0;
         hit_id  <= 3'd0;
         caught  <= 1'b0;
         overrun <= 1'b0;
      end else if (restart) begin
         for (int k = 0; k < N_GHOST; k++) begin
            gx_q[k]  <= INIT_X[k*X_W +: X_W];
            gy_q[k]  <= INIT_Y[k*Y_W +: Y_W];
            dir_q[k] <= DIR_R;
         end
         state   <= ST_IDLE;
         idx     <= '0;
         chk_idx <= '0;
         chk_vld <= 1'b0;
         mode    <= MODE_CHASE;
         phase   <= '0;
         lfsr    <= LFSR_SEED;
         hit     <= 1'b0;
         hit_id  <= 3'd0;
         caught  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         hit     <= 1'b0;
         overrun <= tick && enable && (state == ST_SCAN);
         if (state == ST_SCAN) lfsr <= lfsr_next(lfsr);

         if (coll && state != ST_CAUGHT) begin
            state   <= ST_CAUGHT;
            chk_vld <= 1'b0;
            hit     <= 1'b1;
            hit_id  <= 3'(chk_idx);
            caught  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  chk_vld <= 1'b0;
                  if (accept) begin
                     state <= ST_SCAN;
                     idx   <= '0;
                     if (phase_inc == phase_lim) begin
                        mode  <= ~mode;
                        phase <= '0;
                     end else begin
                        phase <= phase_inc;
                     end
                  end
               end
               ST_SCAN: begin
                  gx_q[idx]  <= nx;
                  gy_q[idx]  <= ny;
                  dir_q[idx] <= ndir;
                  chk_vld    <= 1'b1;
                  chk_idx    <= idx;
                  if (idx == IDX_W'(N_GHOST - 1)) state <= ST_IDLE;
                  else                            idx   <= idx + 1'b1;
               end
               default: chk_vld <= 1'b0;
            endcase
         end
      end
   end

endmodule
